traffic_light_controller: RTL and testbench

Fixed-time, two-way intersection signal controller for North-South (NS) and East-West (EW) approaches. A four-phase Moore FSM advances through NS green, NS yellow, EW green and EW yellow. Each phase lasts a cycle count derived from the clock frequency and the per-colour durations in seconds. The block is standalone: it has no sensor or pedestrian inputs, and its six lamp outputs drive the signal heads directly.

---
 rtl/traffic_light_pkg.sv | 38 +++
 rtl/traffic_light_phase_timer.sv | 25 ++
 rtl/traffic_light_controller.sv | 72 +++++++
 tb/tb_traffic_light_controller.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/traffic_light_pkg.sv
// rtl/traffic_light_pkg.sv - shared phase type, lamp decode and tick arithmetic
package traffic_light_pkg;

  typedef enum logic [1:0] {
    NS_GREEN  = 2'd0,
    NS_YELLOW = 2'd1,
    EW_GREEN  = 2'd2,
    EW_YELLOW = 2'd3
  } phase_e;

  typedef struct packed {
    logic ns_red;
    logic ns_yellow;
    logic ns_green;
    logic ew_red;
    logic ew_yellow;
    logic ew_green;
  } lamps_t;

  function automatic longint unsigned ticks(input longint unsigned freq_hz,
                                            input longint unsigned seconds);
    return freq_hz * seconds;
  endfunction

  function automatic lamps_t phase_lamps(input phase_e phase);
    lamps_t l;
    l = '0;
    case (phase)
      NS_GREEN:  begin l.ns_green  = 1'b1; l.ew_red = 1'b1; end
      NS_YELLOW: begin l.ns_yellow = 1'b1; l.ew_red = 1'b1; end
      EW_GREEN:  begin l.ew_green  = 1'b1; l.ns_red = 1'b1; end
      EW_YELLOW: begin l.ew_yellow = 1'b1; l.ns_red = 1'b1; end
      default:   begin l.ns_green  = 1'b1; l.ew_red = 1'b1; end
    endcase
    return l;
  endfunction

endpackage

// File: rtl/traffic_light_phase_timer.sv
// rtl/traffic_light_phase_timer.sv - phase length counter with terminal-count done pulse
module traffic_light_phase_timer #(
  parameter int CNT_W = 1
) (
  input  logic           clk,
  input  logic           clear,
  input  logic [CNT_W:0] terminal,
  output logic           done
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // terminal is one bit wider than the count so a full 2**CNT_W tick phase fits
  always_comb begin
    done    = ({1'b0, count_q} == (terminal - (CNT_W+1)'(1)));
    count_d = done ? '0 : (count_q + CNT_W'(1));
  end

  always_ff @(posedge clk) begin
    if (clear) count_q <= '0;
    else       count_q <= count_d;
  end

endmodule

// File: rtl/traffic_light_controller.sv
// rtl/traffic_light_controller.sv - fixed-time four-phase two-way intersection controller
module traffic_light_controller
  import traffic_light_pkg::*;
#(
  parameter int unsigned CLOCK_FREQ_HZ = 50_000_000,
  parameter int unsigned GREEN_TIME_S  = 5,
  parameter int unsigned YELLOW_TIME_S = 2
) (
  input  logic clk,
  input  logic rst,
  output logic ns_red,
  output logic ns_yellow,
  output logic ns_green,
  output logic ew_red,
  output logic ew_yellow,
  output logic ew_green
);

  localparam longint unsigned GREEN_TICKS  = ticks(CLOCK_FREQ_HZ, GREEN_TIME_S);
  localparam longint unsigned YELLOW_TICKS = ticks(CLOCK_FREQ_HZ, YELLOW_TIME_S);
  localparam longint unsigned MAX_TICKS    = (GREEN_TICKS > YELLOW_TICKS) ? GREEN_TICKS : YELLOW_TICKS;
  localparam int              CNT_W_RAW    = $clog2(MAX_TICKS);
  localparam int              CNT_W        = (CNT_W_RAW < 1) ? 1 : CNT_W_RAW;

  localparam logic [CNT_W:0] GREEN_TERM  = (CNT_W+1)'(GREEN_TICKS);
  localparam logic [CNT_W:0] YELLOW_TERM = (CNT_W+1)'(YELLOW_TICKS);

  phase_e         phase_q;
  phase_e         phase_d;
  logic           phase_done;
  logic [CNT_W:0] phase_term;
  lamps_t         lamps;

  assign phase_term = ((phase_q == NS_GREEN) || (phase_q == EW_GREEN)) ? GREEN_TERM : YELLOW_TERM;

  traffic_light_phase_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk     (clk),
    .clear   (rst),
    .terminal(phase_term),
    .done    (phase_done)
  );

  always_comb begin
    phase_d = phase_q;
    if (phase_done) begin
      case (phase_q)
        NS_GREEN:  phase_d = NS_YELLOW;
        NS_YELLOW: phase_d = EW_GREEN;
        EW_GREEN:  phase_d = EW_YELLOW;
        EW_YELLOW: phase_d = NS_GREEN;
        default:   phase_d = NS_GREEN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) phase_q <= NS_GREEN;
    else     phase_q <= phase_d;
  end

  // Lamps depend on phase only so counter activity never reaches the signal heads
  assign lamps     = phase_lamps(phase_q);
  assign ns_red    = lamps.ns_red;
  assign ns_yellow = lamps.ns_yellow;
  assign ns_green  = lamps.ns_green;
  assign ew_red    = lamps.ew_red;
  assign ew_yellow = lamps.ew_yellow;
  assign ew_green  = lamps.ew_green;

endmodule

// File: tb/tb_traffic_light_controller.sv
// tb/tb_traffic_light_controller.sv - self-checking bench for traffic_light_controller
module tb_traffic_light_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a;
  logic       rst_o;
  // {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green}
  logic [5:0] lamps_a;
  logic [5:0] lamps_b;
  logic [5:0] lamps_c;

  localparam logic [5:0] L_NSG = 6'b001100;
  localparam logic [5:0] L_NSY = 6'b010100;
  localparam logic [5:0] L_EWG = 6'b100001;
  localparam logic [5:0] L_EWY = 6'b100010;

  traffic_light_controller #(.CLOCK_FREQ_HZ(10), .GREEN_TIME_S(1), .YELLOW_TIME_S(1)) dut_a (
    .clk(clk), .rst(rst_a),
    .ns_red(lamps_a[5]), .ns_yellow(lamps_a[4]), .ns_green(lamps_a[3]),
    .ew_red(lamps_a[2]), .ew_yellow(lamps_a[1]), .ew_green(lamps_a[0])
  );

  traffic_light_controller #(.CLOCK_FREQ_HZ(4), .GREEN_TIME_S(2), .YELLOW_TIME_S(1)) dut_b (
    .clk(clk), .rst(rst_o),
    .ns_red(lamps_b[5]), .ns_yellow(lamps_b[4]), .ns_green(lamps_b[3]),
    .ew_red(lamps_b[2]), .ew_yellow(lamps_b[1]), .ew_green(lamps_b[0])
  );

  traffic_light_controller #(.CLOCK_FREQ_HZ(1), .GREEN_TIME_S(1), .YELLOW_TIME_S(1)) dut_c (
    .clk(clk), .rst(rst_o),
    .ns_red(lamps_c[5]), .ns_yellow(lamps_c[4]), .ns_green(lamps_c[3]),
    .ew_red(lamps_c[2]), .ew_yellow(lamps_c[1]), .ew_green(lamps_c[0])
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit check_en = 1'b0;

  // Model state: number of non-reset edges since the last reset edge
  int t_a = 0;
  int t_b = 0;
  int t_c = 0;

  always @(posedge clk) begin
    t_a <= rst_a ? 0 : t_a + 1;
    t_b <= rst_o ? 0 : t_b + 1;
    t_c <= rst_o ? 0 : t_c + 1;
  end

  function automatic logic [5:0] expect_lamps(input int t, input int g, input int y);
    int pos;
    int phase;
    logic [2:0] ns;
    logic [2:0] ew;
    pos = t % (2 * (g + y));
    if (pos < g)              phase = 0;
    else if (pos < g + y)     phase = 1;
    else if (pos < 2 * g + y) phase = 2;
    else                      phase = 3;
    ns = (phase == 0) ? 3'b001 : (phase == 1) ? 3'b010 : 3'b100;
    ew = (phase == 2) ? 3'b001 : (phase == 3) ? 3'b010 : 3'b100;
    return {ns, ew};
  endfunction

  task automatic check_lamps(input string name, input logic [5:0] act, input logic [5:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: lamps=%b expected=%b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_safe(input string name, input logic [5:0] l);
    n_checks++;
    if (!($onehot(l[5:3]) && $onehot(l[2:0]) && (l[5] | l[2]))) begin
      n_fail++;
      $display("FAIL %s: lamps=%b violate one-hot/red invariant at %0t", name, l, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      check_lamps("model_a", lamps_a, expect_lamps(t_a, 10, 10));
      check_lamps("model_b", lamps_b, expect_lamps(t_b, 8, 4));
      check_lamps("model_c", lamps_c, expect_lamps(t_c, 1, 1));
      check_safe("safe_a", lamps_a);
      check_safe("safe_b", lamps_b);
      check_safe("safe_c", lamps_c);
    end
  end

  int   rise_a[$];
  int   rise_b[$];
  int   rise_c[$];
  logic prev_a;
  logic prev_b;
  logic prev_c;

  initial begin
    rst_a = 1'b1;
    rst_o = 1'b1;
    @(posedge clk);
    check_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_lamps("reset_a", lamps_a, L_NSG);
      check_lamps("reset_b", lamps_b, L_NSG);
      check_lamps("reset_c", lamps_c, L_NSG);
    end
    rst_a = 1'b0;
    rst_o = 1'b0;
    prev_a = lamps_a[3];
    prev_b = lamps_b[3];
    prev_c = lamps_c[3];

    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      case (k)
        9:  check_lamps("a_k9_ns_green", lamps_a, L_NSG);
        10: check_lamps("a_k10_ns_yellow", lamps_a, L_NSY);
        20: check_lamps("a_k20_ew_green", lamps_a, L_EWG);
        30: check_lamps("a_k30_ew_yellow", lamps_a, L_EWY);
        40: check_lamps("a_k40_ns_green", lamps_a, L_NSG);
        default: ;
      endcase
      case (k)
        7:  check_lamps("b_k7_ns_green", lamps_b, L_NSG);
        8:  check_lamps("b_k8_ns_yellow", lamps_b, L_NSY);
        12: check_lamps("b_k12_ew_green", lamps_b, L_EWG);
        20: check_lamps("b_k20_ew_yellow", lamps_b, L_EWY);
        24: check_lamps("b_k24_ns_green", lamps_b, L_NSG);
        default: ;
      endcase
      case (k)
        1: check_lamps("c_k1_ns_yellow", lamps_c, L_NSY);
        2: check_lamps("c_k2_ew_green", lamps_c, L_EWG);
        3: check_lamps("c_k3_ew_yellow", lamps_c, L_EWY);
        4: check_lamps("c_k4_ns_green", lamps_c, L_NSG);
        default: ;
      endcase
      if (lamps_a[3] && !prev_a) rise_a.push_back(k);
      if (lamps_b[3] && !prev_b) rise_b.push_back(k);
      if (lamps_c[3] && !prev_c) rise_c.push_back(k);
      prev_a = lamps_a[3];
      prev_b = lamps_b[3];
      prev_c = lamps_c[3];
    end

    check_int("a_rise_count", rise_a.size(), 5);
    check_int("b_rise_count", rise_b.size(), 8);
    check_int("c_rise_count", rise_c.size(), 50);
    for (int i = 1; i < rise_a.size(); i++) check_int("a_period", rise_a[i] - rise_a[i-1], 40);
    for (int i = 1; i < rise_b.size(); i++) check_int("b_period", rise_b[i] - rise_b[i-1], 24);
    for (int i = 1; i < rise_c.size(); i++) check_int("c_period", rise_c[i] - rise_c[i-1], 4);

    // dut_a is at the start of NS_GREEN; 24 more edges lands on cycle 5 of EW_GREEN
    repeat (24) @(negedge clk);
    check_lamps("a_mid_ew_green", lamps_a, L_EWG);
    rst_a = 1'b1;
    @(negedge clk);
    check_lamps("a_after_mid_reset", lamps_a, L_NSG);
    rst_a = 1'b0;
    repeat (9) @(negedge clk);
    check_lamps("a_reset_full_green", lamps_a, L_NSG);
    @(negedge clk);
    check_lamps("a_reset_then_yellow", lamps_a, L_NSY);

    repeat (1000) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
